// File: rtl/load_store_unit.sv
// Load/store unit: aligns CPU byte/half/word accesses onto a word-wide data memory,
// using a read-modify-write sequence for sub-word stores.
module load_store_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] dm_address,
  output logic        dm_mem_read,
  output logic        dm_mem_write,
  output logic [31:0] dm_data_write,
  input  logic [31:0] dm_read_data
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, and each transfer yields exactly one
  // single-cycle resp_valid pulse (resp_err qualifies it).

  typedef enum logic [2:0] {IDLE, LOAD, STORE_W, RMW_READ, RMW_WRITE} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic        valid_q;
  logic        err_q;

  logic        req_bad;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = (req_addr[1:0] != 2'b00);
      2'b11:   req_bad = 1'b1;
      default: req_bad = 1'b0;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-word stores, little-endian.
  always_comb begin
    lane_byte = dm_read_data[{addr_q[1:0], 3'b000} +: 8];
    lane_half = dm_read_data[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_data = signed_q ? {{24{lane_byte[7]}}, lane_byte} : {24'h0, lane_byte};
      2'b01:   load_data = signed_q ? {{16{lane_half[15]}}, lane_half} : {16'h0, lane_half};
      default: load_data = dm_read_data;
    endcase
    merged = dm_read_data;
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            size_q   <= req_size;
            signed_q <= req_signed;
            if (req_bad) begin
              valid_q <= 1'b1;
              err_q   <= 1'b1;
            end else if (!req_write) begin
              state <= LOAD;
            end else if (req_size == 2'b10) begin
              state <= STORE_W;
            end else begin
              state <= RMW_READ;
            end
          end
        end
        LOAD: begin
          rdata_q <= load_data;
          valid_q <= 1'b1;
          state   <= IDLE;
        end
        STORE_W: begin
          valid_q <= 1'b1;
          state   <= IDLE;
        end
        RMW_READ: begin
          merged_q <= merged;
          state    <= RMW_WRITE;
        end
        RMW_WRITE: begin
          valid_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset masks outputs combinationally so an in-flight write never reaches memory.
  assign req_ready     = (state == IDLE) | reset;
  assign resp_valid    = valid_q & ~reset;
  assign resp_err      = err_q & ~reset;
  assign resp_rdata    = reset ? 32'h0 : rdata_q;
  assign dm_address    = {2'b00, addr_q[31:2]};
  assign dm_mem_read   = ((state == LOAD) || (state == RMW_READ)) & ~reset;
  assign dm_mem_write  = ((state == STORE_W) || (state == RMW_WRITE)) & ~reset;
  assign dm_data_write = !dm_mem_write ? 32'h0 : ((state == STORE_W) ? wdata_q : merged_q);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory attached to the dm_* port.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] dm_address;
  logic        dm_mem_read;
  logic        dm_mem_write;
  logic [31:0] dm_data_write;
  logic [31:0] dm_read_data;

  logic [31:0] mem [0:255] = '{default: 32'h0};
  int n_checks = 0;
  int n_pass = 0;
  int proto_viol = 0;

  always #5 clock = ~clock;

  load_store_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .dm_address(dm_address), .dm_mem_read(dm_mem_read),
    .dm_mem_write(dm_mem_write), .dm_data_write(dm_data_write),
    .dm_read_data(dm_read_data)
  );

  assign dm_read_data = mem[dm_address[7:0]];
  always @(posedge clock) if (dm_mem_write) mem[dm_address[7:0]] <= dm_data_write;

  always @(negedge clock)
    if ((dm_mem_read && dm_mem_write) || (!dm_mem_write && dm_data_write != 32'h0))
      proto_viol++;

  // Issues one request from IDLE and waits (bounded) for its response.
  // lat counts negedges after the acceptance edge; 0 means no response came.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd,
                        output logic touched, output logic [31:0] addr_seen);
    @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(negedge clock);
    req_valid = 1'b0;
    lat = 0; err = 1'b0; rd = 32'h0; touched = 1'b0; addr_seen = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clock);
      if (dm_mem_read || dm_mem_write) begin
        touched = 1'b1;
        addr_seen = dm_address;
      end
      if (resp_valid) begin
        lat = i; err = resp_err; rd = resp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    @(negedge clock);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready: got %b expected 1", req_ready); else n_pass++;
    n_checks++; if ({resp_valid, resp_err, dm_mem_read, dm_mem_write} !== 4'b0000)
      $display("FAIL rst_ctrl: got %b expected 0000", {resp_valid, resp_err, dm_mem_read, dm_mem_write}); else n_pass++;
    n_checks++; if ({resp_rdata, dm_data_write} !== 64'h0)
      $display("FAIL rst_data: got %h expected 0", {resp_rdata, dm_data_write}); else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if ({req_ready, resp_valid} !== 2'b10) $display("FAIL rst_release: got %b expected 10", {req_ready, resp_valid}); else n_pass++;
  endtask

  task automatic test_word();
    int lat; logic err, t; logic [31:0] rd, as;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, err, rd, t, as);
    n_checks++; if (lat !== 2) $display("FAIL sw_lat: got %0d expected 2", lat); else n_pass++;
    n_checks++; if ({err, rd} !== 33'h0) $display("FAIL sw_resp: got %b/%h expected 0/0", err, rd); else n_pass++;
    n_checks++; if (as !== 32'h4) $display("FAIL sw_addr: got %h expected 4", as); else n_pass++;
    n_checks++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL sw_mem: got %h expected deadbeef", mem[4]); else n_pass++;
    do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, lat, err, rd, t, as);
    n_checks++; if (lat !== 2) $display("FAIL lw_lat: got %0d expected 2", lat); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_data: got %h expected deadbeef", rd); else n_pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0, lat, err, rd, t, as);
    n_checks++; if (as !== 32'h2000_0004) $display("FAIL lw_alias_addr: got %h expected 20000004", as); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_alias_data: got %h expected deadbeef", rd); else n_pass++;
  endtask

  task automatic test_byte();
    int lat; logic err, t; logic [31:0] rd, as;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_5655, lat, err, rd, t, as);
    n_checks++; if (lat !== 3) $display("FAIL sb_lat: got %0d expected 3", lat); else n_pass++;
    n_checks++; if (mem[4] !== 32'hDEAD55EF) $display("FAIL sb_mem: got %h expected dead55ef", mem[4]); else n_pass++;
    do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, err, rd, t, as);
    n_checks++; if (rd !== 32'hFFFFFFDE) $display("FAIL lb_neg: got %h expected ffffffde", rd); else n_pass++;
    do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, err, rd, t, as);
    n_checks++; if (rd !== 32'h000000DE) $display("FAIL lbu: got %h expected 000000de", rd); else n_pass++;
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, err, rd, t, as);
    n_checks++; if (rd !== 32'h00000055) $display("FAIL lb_pos: got %h expected 00000055", rd); else n_pass++;
  endtask

  task automatic test_half();
    int lat; logic err, t; logic [31:0] rd, as;
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0000_1234, lat, err, rd, t, as);
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_8001, lat, err, rd, t, as);
    n_checks++; if (lat !== 3) $display("FAIL sh_lat: got %0d expected 3", lat); else n_pass++;
    n_checks++; if (mem[8] !== 32'h8001_1234) $display("FAIL sh_mem: got %h expected 80011234", mem[8]); else n_pass++;
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat, err, rd, t, as);
    n_checks++; if (rd !== 32'hFFFF8001) $display("FAIL lh: got %h expected ffff8001", rd); else n_pass++;
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, lat, err, rd, t, as);
    n_checks++; if (rd !== 32'h00008001) $display("FAIL lhu: got %h expected 00008001", rd); else n_pass++;
    do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, lat, err, rd, t, as);
    n_checks++; if (rd !== 32'h00001234) $display("FAIL lh_low: got %h expected 00001234", rd); else n_pass++;
  endtask

  task automatic test_errors();
    int lat; logic err, t; logic [31:0] rd, as;
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, err, rd, t, as);
    n_checks++; if ({lat, err, rd, t} !== {32'd1, 1'b1, 32'h0, 1'b0})
      $display("FAIL err_lw: got lat=%0d err=%b rd=%h mem=%b expected 1/1/0/0", lat, err, rd, t); else n_pass++;
    do_req(1'b0, 2'b01, 1'b1, 32'h05, 32'h0, lat, err, rd, t, as);
    n_checks++; if ({lat, err, rd, t} !== {32'd1, 1'b1, 32'h0, 1'b0})
      $display("FAIL err_lh: got lat=%0d err=%b rd=%h mem=%b expected 1/1/0/0", lat, err, rd, t); else n_pass++;
    do_req(1'b0, 2'b11, 1'b0, 32'h08, 32'h0, lat, err, rd, t, as);
    n_checks++; if ({lat, err} !== {32'd1, 1'b1}) $display("FAIL err_size: got lat=%0d err=%b expected 1/1", lat, err); else n_pass++;
    do_req(1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF, lat, err, rd, t, as);
    n_checks++; if ({lat, err, t} !== {32'd1, 1'b1, 1'b0}) $display("FAIL err_sw: got lat=%0d err=%b mem=%b expected 1/1/0", lat, err, t); else n_pass++;
    n_checks++; if (mem[1] !== 32'h0) $display("FAIL err_sw_mem: got %h expected 0", mem[1]); else n_pass++;
    do_req(1'b1, 2'b00, 1'b0, 32'h07, 32'h0000_00A5, lat, err, rd, t, as);
    n_checks++; if ({lat, err} !== {32'd3, 1'b0}) $display("FAIL sb_off3: got lat=%0d err=%b expected 3/0", lat, err); else n_pass++;
    do_req(1'b0, 2'b00, 1'b1, 32'h07, 32'h0, lat, err, rd, t, as);
    n_checks++; if (rd !== 32'hFFFFFFA5) $display("FAIL lb_off3: got %h expected ffffffa5", rd); else n_pass++;
    do_req(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, lat, err, rd, t, as);
    n_checks++; if ({err, rd} !== {1'b0, 32'h0000A500}) $display("FAIL lhu_off2: got %b/%h expected 0/0000a500", err, rd); else n_pass++;
  endtask

  task automatic test_reset_in_rmw();
    logic saw_resp;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h12; req_wdata = 32'h77;
    @(negedge clock);
    req_valid = 1'b0;
    n_checks++; if (dm_mem_read !== 1'b1) $display("FAIL rmw_read: got %b expected 1", dm_mem_read); else n_pass++;
    @(negedge clock);
    n_checks++; if (dm_mem_write !== 1'b1) $display("FAIL rmw_write: got %b expected 1", dm_mem_write); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if ({dm_mem_write, dm_data_write} !== 33'h0)
      $display("FAIL rst_gate: got %b/%h expected 0/0", dm_mem_write, dm_data_write); else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_rmw_ready: got %b expected 1", req_ready); else n_pass++;
    n_checks++; if (mem[4] !== 32'hDEAD55EF) $display("FAIL rst_rmw_mem: got %h expected dead55ef", mem[4]); else n_pass++;
    saw_resp = resp_valid;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      saw_resp = saw_resp | resp_valid;
    end
    n_checks++; if (saw_resp !== 1'b0) $display("FAIL rst_rmw_resp: got %b expected 0", saw_resp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nresp;
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    @(negedge clock);
    req_size = 2'b00; req_addr = 32'h13;
    n_checks++; if ({req_ready, resp_valid} !== 2'b00) $display("FAIL b2b_busy: got %b expected 00", {req_ready, resp_valid}); else n_pass++;
    @(negedge clock);
    n_checks++; if ({resp_valid, req_ready, resp_rdata} !== {2'b11, 32'hDEAD55EF})
      $display("FAIL b2b_first: got %b/%h expected 11/dead55ef", {resp_valid, req_ready}, resp_rdata); else n_pass++;
    @(negedge clock);
    req_valid = 1'b0;
    n_checks++; if ({resp_valid, req_ready} !== 2'b00) $display("FAIL b2b_accept: got %b expected 00", {resp_valid, req_ready}); else n_pass++;
    @(negedge clock);
    n_checks++; if ({resp_valid, resp_rdata} !== {1'b1, 32'h000000DE})
      $display("FAIL b2b_second: got %b/%h expected 1/000000de", resp_valid, resp_rdata); else n_pass++;
    nresp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (resp_valid) nresp++;
    end
    n_checks++; if (nresp !== 0) $display("FAIL b2b_dup: got %0d expected 0", nresp); else n_pass++;
  endtask

  task automatic test_protocol();
    n_checks++; if (proto_viol !== 0) $display("FAIL dm_protocol: got %0d violations expected 0", proto_viol); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_in_rmw();
    test_back_to_back();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
